reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Shares the single write port of the LC-3 8×16 register file (ld_reg / dr_addr / from_bus) between several writeback requesters: ALU result, memory load data, and debug/program loader.
- Sits between the execute/memory stages and Reg_File.
- Grants one requester per cycle and registers the winner onto the write port.
- Tracks in-flight writes per register so decode can stall on hazards.

Parameters:
- NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = MEM, 2 = DBG).
- DATA_W, 16, register/bus width.
- ADDR_W, 3, register address width (8 registers).
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- wb_hold  in  1  freeze: no new grants while high; a write already on the port completes.
- req  in  NUM_REQ  per-requester write request; held until granted.
- req_addr  in  NUM_REQ×ADDR_W  destination register per requester.
- req_data  in  NUM_REQ×DATA_W  write data per requester.
- gnt  out  NUM_REQ  one-hot combinational grant, valid in the cycle it is high.
- ld_reg  out  1  register-file write enable (registered).
- dr_addr  out  ADDR_W  register-file destination (registered).
- from_bus  out  DATA_W  register-file write data (registered).
- wr_pending  out  8  bit r = 1 while a granted write to Rr has not yet landed.
- sr1_addr, sr2_addr  in  ADDR_W  current read addresses (used by forwarding).
- sr1_rf, sr2_rf  in  DATA_W  raw Reg_File read data.
- sr1_out, sr2_out  out  DATA_W  read data to datapath.

Behaviour:
- Reset (async, immediate):
  - ld_reg = 0, dr_addr = 0, from_bus = 0, gnt = 0.
  - wr_pending = 0; RR pointer = 0 (requester 0 highest).
  - Any in-flight write is dropped.
- Grant is combinational in cycle N:
  - gnt = 0 if wb_hold or no req.
  - Fixed mode: gnt = lowest-index asserted req.
  - RR mode: search starts at (last_grant+1) mod NUM_REQ.
- Posedge ending cycle N with gnt[i] = 1:
  - dr_addr ← req_addr[i], from_bus ← req_data[i], ld_reg ← 1.
  - RR pointer ← i.
  - wr_pending[req_addr[i]] ← 1.
- Cycle N+1: ld_reg high; Reg_File captures on the posedge ending N+1.
  - At that posedge, wr_pending[dr_addr] clears unless a new grant targets the same register in N+1; set wins.
- Latency: req sampled → register updated at the 2nd posedge. Throughput: one write per cycle (back-to-back grants keep ld_reg high).
- Handshake: requester deasserts req (or presents the next write) after the posedge where its gnt was high. req without gnt holds addr/data stable.
- No grant in a cycle → ld_reg ← 0 at the next posedge; dr_addr/from_bus hold their last value.
- Same register targeted by two requesters: writes are serialized in grant order; last granted value remains.
- wb_hold asserted while req is pending: request waits; the RR pointer does not advance.
- DBG requester (index 2) has no special priority in RR mode; fixed mode gives it lowest priority.
- Without forwarding: sr1_out = sr1_rf, sr2_out = sr2_rf (pure wires).

Optional Feature:
- Macro WB_FWD_EN.
- Defined: if ld_reg && sr1_addr == dr_addr, then sr1_out = from_bus, else sr1_rf; sr2 is handled identically. This gives read-during-write the NEW value in the same cycle. wr_pending is unchanged.
- Undefined: sr1_out/sr2_out pass through; read during write shows the OLD value, matching Reg_File.

Decomposition:
- Package lc3_wb_pkg:
  - DATA_W = 16, ADDR_W = 3, NUM_REGS = 8.
  - Requester index constants WB_ALU = 0, WB_MEM = 1, WB_DBG = 2.
  - Typedef wb_req_t {addr, data}.
  - Enum arb_mode_e {ARB_FIXED, ARB_RR}.
- One sub-module, wb_rr_arbiter: parameterized combinational grant plus registered pointer.
- Write-port registers, pending scoreboard and forwarding mux stay in reg_wb_arbiter.

Test Plan:
- Single write: after reset, req[0] with R1 = 0x000F for one grant → gnt = 001 in cycle N; ld_reg = 1, dr_addr = 1, from_bus = 0x000F in N+1; wr_pending[1] high in N+1, low after.
- RR contention: req = 111 held, targets R2/R3/R4 with 0x1111/0x2222/0x3333 → grant order 0, 1, 2; ld_reg high 3 consecutive cycles; R2/R3/R4 hold the values.
- Fixed mode (ARB_MODE = 0): req = 110 → gnt = 010 first, then 100.
- Same-reg collision: req[0] R7 = 0xF000 and req[1] R7 = 0x1234 simultaneously (RR pointer 0) → grant order 1 then 0 in RR mode; final R7 = 0xF000; wr_pending[7] stays high across both writes.
- wb_hold: hold = 1 for 4 cycles with req[1] pending → gnt = 0 and ld_reg = 0 throughout; grant in the first cycle after release.
- Reset mid-write: assert reset during the ld_reg = 1 cycle → ld_reg, dr_addr and wr_pending cleared immediately. With WB_FWD_EN, a read of R4 while writing 0x00F0 returns 0x00F0 on sr1_out; without it, the old value is returned.

Source files
------------

// File: rtl/lc3_wb_pkg.sv
// Shared constants and types for the LC-3 register-file writeback arbiter.
package lc3_wb_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam int WB_ALU = 0;
    localparam int WB_MEM = 1;
    localparam int WB_DBG = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational one-hot grant (fixed priority or round-robin) with a
// registered last-grant pointer that only moves when a grant is issued.
module wb_rr_arbiter
    import lc3_wb_pkg::*;
#(
    parameter  int NUM_REQ  = 3,
    parameter  int ARB_MODE = 1,
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx
);

    logic [PTR_W-1:0] ptr;
    logic             found;
    int               idx;

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                // Round-robin search begins just past the last winner.
                idx = (ARB_MODE == int'(ARB_RR)) ? (int'(ptr) + 1 + k) % NUM_REQ : k;
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_idx  = PTR_W'(idx);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the LC-3 register file write port with a per-register
// pending scoreboard. Define WB_FWD_EN to forward the in-flight write to reads.
module reg_wb_arbiter
    import lc3_wb_pkg::wb_req_t;
    import lc3_wb_pkg::NUM_REGS;
#(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ARB_MODE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_hold,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      ld_reg,
    output logic [ADDR_W-1:0]         dr_addr,
    output logic [DATA_W-1:0]         from_bus,
    output logic [NUM_REGS-1:0]       wr_pending,
    input  logic [ADDR_W-1:0]         sr1_addr,
    input  logic [ADDR_W-1:0]         sr2_addr,
    input  logic [DATA_W-1:0]         sr1_rf,
    input  logic [DATA_W-1:0]         sr2_rf,
    output logic [DATA_W-1:0]         sr1_out,
    output logic [DATA_W-1:0]         sr2_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wb_req_t               reqs [NUM_REQ];
    wb_req_t               win;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_valid;
    logic [NUM_REGS-1:0]   pending_next;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].addr = req_addr[i*ADDR_W +: ADDR_W];
            reqs[i].data = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Reset also masks the grant so nothing is issued while it is held.
    wb_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (~wb_hold & ~reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_valid = |gnt;
    assign win       = reqs[gnt_idx];

    // The landing write clears its bit first so a same-register grant re-sets it.
    always_comb begin
        pending_next = wr_pending;
        if (ld_reg)    pending_next[dr_addr]  = 1'b0;
        if (gnt_valid) pending_next[win.addr] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_reg     <= 1'b0;
            dr_addr    <= '0;
            from_bus   <= '0;
            wr_pending <= '0;
        end else begin
            ld_reg     <= gnt_valid;
            wr_pending <= pending_next;
            if (gnt_valid) begin
                dr_addr  <= win.addr;
                from_bus <= win.data;
            end
        end
    end

`ifdef WB_FWD_EN
    assign sr1_out = (ld_reg && sr1_addr == dr_addr) ? from_bus : sr1_rf;
    assign sr2_out = (ld_reg && sr2_addr == dr_addr) ? from_bus : sr2_rf;
`else
    wire unused_sr_addr = ^{sr1_addr, sr2_addr};
    assign sr1_out = sr1_rf;
    assign sr2_out = sr2_rf;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share stimulus;
// a small register-file model captures the round-robin write port.
module tb_reg_wb_arbiter;

    typedef struct {
        logic [2:0]  req;
        logic        hold;
        logic [8:0]  addr;
        logic [47:0] data;
        logic [2:0]  exp_gnt;
        logic        exp_ld;
        logic [2:0]  exp_dr;
        logic [15:0] exp_fb;
        logic [7:0]  exp_pend;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        wb_hold;
    logic [2:0]  req;
    logic [8:0]  req_addr;
    logic [47:0] req_data;
    logic [2:0]  sr1_addr, sr2_addr;
    logic [15:0] sr1_rf, sr2_rf;

    logic [2:0]  gnt_rr, gnt_fx;
    logic        ld_rr, ld_fx;
    logic [2:0]  dr_rr, dr_fx;
    logic [15:0] fb_rr, fb_fx;
    logic [7:0]  pend_rr, pend_fx;
    logic [15:0] sr1_out_rr, sr2_out_rr, sr1_out_fx, sr2_out_fx;

    logic [15:0] rf [8];

    int n_checks = 0;
    int n_errors = 0;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    reg_wb_arbiter #(.ARB_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .wb_hold(wb_hold), .req(req),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt_rr),
        .ld_reg(ld_rr), .dr_addr(dr_rr), .from_bus(fb_rr), .wr_pending(pend_rr),
        .sr1_addr(sr1_addr), .sr2_addr(sr2_addr), .sr1_rf(sr1_rf), .sr2_rf(sr2_rf),
        .sr1_out(sr1_out_rr), .sr2_out(sr2_out_rr)
    );

    reg_wb_arbiter #(.ARB_MODE(0)) dut_fx (
        .clk(clk), .reset(reset), .wb_hold(wb_hold), .req(req),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt_fx),
        .ld_reg(ld_fx), .dr_addr(dr_fx), .from_bus(fb_fx), .wr_pending(pend_fx),
        .sr1_addr(sr1_addr), .sr2_addr(sr2_addr), .sr1_rf(sr1_rf), .sr2_rf(sr2_rf),
        .sr1_out(sr1_out_fx), .sr2_out(sr2_out_fx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ld_rr) rf[dr_rr] <= fb_rr;
    end
    assign sr1_rf = rf[sr1_addr];
    assign sr2_rf = rf[sr2_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] r, input logic h, input logic [8:0] a,
                                input logic [47:0] d, input logic [2:0] g, input logic ld,
                                input logic [2:0] dr, input logic [15:0] fb, input logic [7:0] pd);
        vec_t v;
        v.req = r; v.hold = h; v.addr = a; v.data = d;
        v.exp_gnt = g; v.exp_ld = ld; v.exp_dr = dr; v.exp_fb = fb; v.exp_pend = pd;
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        reset    = 1'b1;
        wb_hold  = 1'b0;
        req      = 3'b001;
        req_addr = '0;
        req_data = '0;
        sr1_addr = '0;
        sr2_addr = '0;

        // Single write, pointer setup, 3-way contention, then a 4-cycle hold.
        tbl[0]  = mk(3'b001, 0, 9'o001, 48'h0000_0000_000F, 3'b001, 0, 3'd0, 16'h0000, 8'h00);
        tbl[1]  = mk(3'b000, 0, 9'o001, 48'h0000_0000_000F, 3'b000, 1, 3'd1, 16'h000F, 8'h02);
        tbl[2]  = mk(3'b000, 0, 9'o001, 48'h0000_0000_000F, 3'b000, 0, 3'd1, 16'h000F, 8'h00);
        tbl[3]  = mk(3'b100, 0, 9'o500, 48'h5555_0000_0000, 3'b100, 0, 3'd1, 16'h000F, 8'h00);
        tbl[4]  = mk(3'b111, 0, 9'o432, 48'h3333_2222_1111, 3'b001, 1, 3'd5, 16'h5555, 8'h20);
        tbl[5]  = mk(3'b110, 0, 9'o432, 48'h3333_2222_1111, 3'b010, 1, 3'd2, 16'h1111, 8'h04);
        tbl[6]  = mk(3'b100, 0, 9'o432, 48'h3333_2222_1111, 3'b100, 1, 3'd3, 16'h2222, 8'h08);
        tbl[7]  = mk(3'b000, 0, 9'o432, 48'h3333_2222_1111, 3'b000, 1, 3'd4, 16'h3333, 8'h10);
        tbl[8]  = mk(3'b000, 0, 9'o432, 48'h3333_2222_1111, 3'b000, 0, 3'd4, 16'h3333, 8'h00);
        tbl[9]  = mk(3'b010, 1, 9'o060, 48'h0000_6666_0000, 3'b000, 0, 3'd4, 16'h3333, 8'h00);
        tbl[10] = mk(3'b010, 1, 9'o060, 48'h0000_6666_0000, 3'b000, 0, 3'd4, 16'h3333, 8'h00);
        tbl[11] = mk(3'b010, 1, 9'o060, 48'h0000_6666_0000, 3'b000, 0, 3'd4, 16'h3333, 8'h00);
        tbl[12] = mk(3'b010, 1, 9'o060, 48'h0000_6666_0000, 3'b000, 0, 3'd4, 16'h3333, 8'h00);
        tbl[13] = mk(3'b010, 0, 9'o060, 48'h0000_6666_0000, 3'b010, 0, 3'd4, 16'h3333, 8'h00);
        tbl[14] = mk(3'b000, 0, 9'o060, 48'h0000_6666_0000, 3'b000, 1, 3'd6, 16'h6666, 8'h40);
        tbl[15] = mk(3'b000, 0, 9'o060, 48'h0000_6666_0000, 3'b000, 0, 3'd6, 16'h6666, 8'h00);

        // Reset state, with a request present to show the grant is masked.
        step();
        check("reset_gnt", 32'(gnt_rr), 32'h0);
        check("reset_ld", 32'(ld_rr), 32'h0);
        check("reset_dr", 32'(dr_rr), 32'h0);
        check("reset_fb", 32'(fb_rr), 32'h0);
        check("reset_pend", 32'(pend_rr), 32'h0);
        step();
        reset = 1'b0;
        req   = 3'b000;
        step();

        for (int i = 0; i < 16; i++) begin
            req      = tbl[i].req;
            wb_hold  = tbl[i].hold;
            req_addr = tbl[i].addr;
            req_data = tbl[i].data;
            #1;
            check($sformatf("v%0d_gnt", i), 32'(gnt_rr), 32'(tbl[i].exp_gnt));
            check($sformatf("v%0d_ld", i), 32'(ld_rr), 32'(tbl[i].exp_ld));
            check($sformatf("v%0d_dr", i), 32'(dr_rr), 32'(tbl[i].exp_dr));
            check($sformatf("v%0d_fb", i), 32'(fb_rr), 32'(tbl[i].exp_fb));
            check($sformatf("v%0d_pend", i), 32'(pend_rr), 32'(tbl[i].exp_pend));
            step();
        end

        // Register-file contents after the table.
        sr1_addr = 3'd1; #1; check("rf_r1", 32'(sr1_out_rr), 32'h000F);
        sr1_addr = 3'd2; #1; check("rf_r2", 32'(sr1_out_rr), 32'h1111);
        sr1_addr = 3'd3; #1; check("rf_r3", 32'(sr1_out_rr), 32'h2222);
        sr1_addr = 3'd4; #1; check("rf_r4", 32'(sr1_out_rr), 32'h3333);
        sr1_addr = 3'd5; #1; check("rf_r5", 32'(sr1_out_rr), 32'h5555);
        sr1_addr = 3'd6; #1; check("rf_r6", 32'(sr1_out_rr), 32'h6666);
        step();

        // Read R4 during its write, then reset in the ld_reg cycle (pointer is 1).
        sr1_addr = 3'd4;
        req      = 3'b001;
        req_addr = 9'o004;
        req_data = 48'h0000_0000_00F0;
        #1;
        check("fwd_gnt", 32'(gnt_rr), 32'h1);
        step();
        req = 3'b000;
        #1;
        check("fwd_ld", 32'(ld_rr), 32'h1);
        check("fwd_pend", 32'(pend_rr), 32'h10);
        check("fwd_sr1", 32'(sr1_out_rr), FWD ? 32'h00F0 : 32'h3333);
        reset = 1'b1;
        #1;
        check("rst_mid_ld", 32'(ld_rr), 32'h0);
        check("rst_mid_dr", 32'(dr_rr), 32'h0);
        check("rst_mid_fb", 32'(fb_rr), 32'h0);
        check("rst_mid_pend", 32'(pend_rr), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("rst_mid_r4_kept", 32'(sr1_out_rr), 32'h3333);

        // Same-register collision with the pointer at 0: R7 gets 1234 then F000.
        req      = 3'b011;
        req_addr = 9'o077;
        req_data = 48'h0000_1234_F000;
        #1;
        check("col_gnt1", 32'(gnt_rr), 32'h2);
        step();
        req = 3'b001;
        #1;
        check("col_gnt0", 32'(gnt_rr), 32'h1);
        check("col_fb1", 32'(fb_rr), 32'h1234);
        check("col_pend1", 32'(pend_rr), 32'h80);
        step();
        req = 3'b000;
        #1;
        check("col_ld2", 32'(ld_rr), 32'h1);
        check("col_fb2", 32'(fb_rr), 32'hF000);
        check("col_pend2", 32'(pend_rr), 32'h80);
        step();
        sr2_addr = 3'd7;
        #1;
        check("col_ld_off", 32'(ld_rr), 32'h0);
        check("col_pend_clr", 32'(pend_rr), 32'h00);
        check("col_r7", 32'(sr2_out_rr), 32'hF000);

        // Fixed priority on the second instance.
        pulse_reset();
        req      = 3'b110;
        req_addr = 9'o210;
        req_data = 48'hBBBB_AAAA_0000;
        #1;
        check("fx_gnt_first", 32'(gnt_fx), 32'h2);
        step();
        req = 3'b100;
        #1;
        check("fx_gnt_second", 32'(gnt_fx), 32'h4);
        check("fx_dr", 32'(dr_fx), 32'h1);
        check("fx_fb", 32'(fb_fx), 32'hAAAA);
        step();
        req = 3'b111;
        #1;
        check("fx_gnt_lowest", 32'(gnt_fx), 32'h1);
        check("fx_fb2", 32'(fb_fx), 32'hBBBB);
        step();
        req = 3'b000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
